// File: rtl/result_collect_stage.sv
// Per-channel result collector: FWFT FIFO, 1-cycle enq-to-out latency, no in->out bypass.
// Stall raised from registered occupancy at DEPTH-SKID; a result arriving while full is dropped and flagged.
module result_collect_stage #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int SKID  = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_flush,
  output logic             out_stall,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic             out_flush,
  output logic [15:0]      out_count,
  output logic             overflow_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
  localparam logic [CW-1:0] STALL_CNT = CW'(DEPTH - SKID);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             flush_q;
  logic [15:0]      out_count_q, out_count_d;
  logic             ovf_q, ovf_d;

  logic full, deq, enq, drop;

  assign full = (count_q == FULL_CNT);
  assign deq  = out_valid & out_ready & ~in_flush;
  assign enq  = in_valid & ~in_flush & (~full | deq);
  assign drop = in_valid & ~in_flush & full & ~deq;

  always_comb begin
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;
    out_count_d = out_count_q;
    ovf_d       = ovf_q | drop;
    if (in_flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (deq) rd_ptr_d = rd_ptr_q + 1'b1;
      if (enq) wr_ptr_d = wr_ptr_q + 1'b1;
      // Simultaneous enq/deq cancel, so full stays full and one stays one.
      if (enq && !deq)      count_d = count_q + 1'b1;
      else if (deq && !enq) count_d = count_q - 1'b1;
    end
    if (enq) out_count_d = out_count_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      flush_q     <= 1'b0;
      out_count_q <= '0;
      ovf_q       <= 1'b0;
    end else begin
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      flush_q     <= in_flush;
      out_count_q <= out_count_d;
      ovf_q       <= ovf_d;
    end
  end

  // Storage carries no reset; validity is tracked by count_q alone.
  always_ff @(posedge clk) begin
    if (reset && enq) mem_q[wr_ptr_q] <= in_data;
  end

  assign out_valid    = (count_q != '0);
  assign out_data     = mem_q[rd_ptr_q];
  assign out_stall    = (count_q >= STALL_CNT);
  assign out_flush    = flush_q;
  assign out_count    = out_count_q;
  assign overflow_err = ovf_q;

endmodule

// File: tb/tb_result_collect_stage.sv
// Directed bench for result_collect_stage with a queue scoreboard of expected results.
module tb_result_collect_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_flush;
  logic        out_stall;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_ready;
  logic        out_flush;
  logic [15:0] out_count;
  logic        overflow_err;

  always #5 clk = ~clk;

  result_collect_stage #(.WIDTH(32), .DEPTH(4), .SKID(1)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_data(in_data), .in_flush(in_flush),
    .out_stall(out_stall), .out_valid(out_valid), .out_data(out_data),
    .out_ready(out_ready), .out_flush(out_flush), .out_count(out_count),
    .overflow_err(overflow_err)
  );

  logic [31:0] sb[$];
  logic [15:0] m_cnt;
  logic        m_ovf;
  logic        m_flush;
  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, check head state, advance the model, then check registered outputs.
  task automatic cyc(input logic v, input logic [31:0] d, input logic f, input logic rdy);
    int   n;
    logic dq, eq;
    in_valid = v; in_data = d; in_flush = f; out_ready = rdy;
    #1;
    n = sb.size();
    chk("out_valid", out_valid, 32'(n != 0));
    if (n != 0) chk("out_data", out_data, sb[0]);
    chk("out_stall", out_stall, 32'(n >= 3));
    dq = (n != 0) && rdy && !f;
    eq = v && !f && ((n < 4) || dq);
    if (f) sb.delete();
    else begin
      if (dq) void'(sb.pop_front());
      if (eq) sb.push_back(d);
      if (v && !eq) m_ovf = 1'b1;
    end
    if (eq) m_cnt = m_cnt + 16'd1;
    m_flush = f;
    @(posedge clk); #1;
    chk("out_flush", out_flush, 32'(m_flush));
    chk("out_count", out_count, 32'(m_cnt));
    chk("overflow_err", overflow_err, 32'(m_ovf));
  endtask

  task automatic do_reset(input int n);
    reset = 1'b0; in_valid = 1'b1; in_data = 32'hDEAD_BEEF; in_flush = 1'b0; out_ready = 1'b1;
    repeat (n) begin
      @(posedge clk); #1;
      chk("rst_valid", out_valid, 0);
      chk("rst_stall", out_stall, 0);
      chk("rst_flush", out_flush, 0);
      chk("rst_count", out_count, 0);
      chk("rst_ovf", overflow_err, 0);
    end
    sb.delete();
    m_cnt = '0; m_ovf = 1'b0; m_flush = 1'b0;
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
  endtask

  initial begin
    // Reset held for two cycles with traffic present, then first result.
    do_reset(2);
    cyc(1'b1, 32'hA5A5_A5A5, 1'b0, 1'b0);
    chk("first_valid", out_valid, 1);
    chk("first_data", out_data, 32'hA5A5_A5A5);
    chk("first_count", out_count, 1);
    cyc(1'b0, 32'h0, 1'b0, 1'b1);

    // Stall threshold, full, drop, then ordered drain.
    do_reset(1);
    cyc(1'b1, 32'h1, 1'b0, 1'b0);
    cyc(1'b1, 32'h2, 1'b0, 1'b0);
    chk("stall_at2", out_stall, 0);
    cyc(1'b1, 32'h3, 1'b0, 1'b0);
    chk("stall_after3", out_stall, 1);
    cyc(1'b1, 32'h4, 1'b0, 1'b0);
    chk("ovf_before_drop", overflow_err, 0);
    cyc(1'b1, 32'h5, 1'b0, 1'b0);
    chk("ovf_set", overflow_err, 1);
    chk("cnt_after_drop", out_count, 4);
    for (int i = 0; i < 4; i++) cyc(1'b0, 32'h0, 1'b0, 1'b1);
    chk("drained_valid", out_valid, 0);
    chk("ovf_sticky", overflow_err, 1);

    // Full with simultaneous enq and deq; pointer wrap shown by read order.
    do_reset(1);
    for (int i = 1; i <= 4; i++) cyc(1'b1, 32'(i), 1'b0, 1'b0);
    cyc(1'b1, 32'h9, 1'b0, 1'b1);
    chk("full_keep_stall", out_stall, 1);
    chk("full_no_ovf", overflow_err, 0);
    chk("full_head", out_data, 32'h2);
    for (int i = 0; i < 4; i++) cyc(1'b0, 32'h0, 1'b0, 1'b1);

    // Streaming at one result per cycle.
    do_reset(1);
    for (int i = 0; i < 20; i++) begin
      cyc(1'b1, 32'h100 + 32'(i), 1'b0, 1'b1);
      chk("stream_stall", out_stall, 0);
      chk("stream_head", out_data, 32'h100 + 32'(i));
    end
    cyc(1'b0, 32'h0, 1'b0, 1'b1);
    chk("stream_count", out_count, 20);

    // Flush colliding with valid data and a ready consumer, then back-to-back flushes.
    do_reset(1);
    for (int i = 0; i < 3; i++) cyc(1'b1, 32'h30 + 32'(i), 1'b0, 1'b0);
    cyc(1'b1, 32'hBAD0_BAD0, 1'b1, 1'b1);
    chk("flush_valid", out_valid, 0);
    chk("flush_pulse", out_flush, 1);
    chk("flush_count", out_count, 3);
    cyc(1'b0, 32'h0, 1'b0, 1'b1);
    chk("flush_pulse_end", out_flush, 0);
    cyc(1'b0, 32'h0, 1'b1, 1'b0);
    cyc(1'b0, 32'h0, 1'b1, 1'b0);
    chk("flush_held", out_flush, 1);
    cyc(1'b0, 32'h0, 1'b0, 1'b0);

    // Accepted-result counter wrap.
    do_reset(1);
    for (int i = 0; i < 65535; i++) cyc(1'b1, 32'(i), 1'b0, 1'b1);
    chk("cnt_ffff", out_count, 32'h0000_FFFF);
    cyc(1'b1, 32'hCAFE_0000, 1'b0, 1'b1);
    chk("cnt_wrap", out_count, 0);
    cyc(1'b0, 32'h0, 1'b0, 1'b1);

    // Mid-run reset with two entries held and overflow flagged.
    for (int i = 0; i < 5; i++) cyc(1'b1, 32'h50 + 32'(i), 1'b0, 1'b0);
    cyc(1'b0, 32'h0, 1'b0, 1'b1);
    cyc(1'b0, 32'h0, 1'b0, 1'b1);
    chk("pre_rst_valid", out_valid, 1);
    chk("pre_rst_ovf", overflow_err, 1);
    do_reset(1);
    cyc(1'b0, 32'h0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
